// File: rtl/prog_seq_if.sv
// Bundles the program-sequencer control inputs and status outputs.
// master drives the controls; slave is the sequencer itself.
interface prog_seq_if #(
  parameter int unsigned D = 9
);
  logic         req;
  logic         stall;
  logic         halt;
  logic         ret;
  logic         call;
  logic         absj;
  logic         relj;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         busy;
  logic         done;
  logic         stack_err;

  modport master (
    output req, stall, halt, ret, call, absj, relj, target,
    input  prog_ctr, busy, done, stack_err
  );

  modport slave (
    input  req, stall, halt, ret, call, absj, relj, target,
    output prog_ctr, busy, done, stack_err
  );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: walks a D-bit address space with call/return stack,
// absolute/relative jumps, halt and a req/done start handshake.
module prog_seq #(
  parameter int unsigned D = 9,
  parameter int unsigned S = 4
) (
  input  logic      clk,
  input  logic      reset,
  prog_seq_if.slave bus
);
  localparam int unsigned SPW = $clog2(S + 1);
  localparam int unsigned AW  = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [D-1:0]   r_pc;
  logic [D-1:0]   w_pc_nxt;
  logic [D-1:0]   w_pc_inc;
  logic [D-1:0]   w_pop_data;
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_sp_nxt;
  logic           r_err;
  logic           w_err_nxt;
  logic           r_busy;
  logic           r_done;
  logic           w_push;
  logic           w_step;
  logic           w_empty;
  logic           w_full;
  logic [AW-1:0]  w_top_idx;
  logic [AW-1:0]  w_push_idx;
  logic [D-1:0]   r_stack [S];

  assign w_pc_inc   = r_pc + D'(1);
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SPW'(S));
  assign w_top_idx  = AW'(r_sp - SPW'(1));
  assign w_push_idx = AW'(r_sp);
  assign w_pop_data = r_stack[w_top_idx];

  // Next-state and datapath decode; one action per unstalled RUN cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_step      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pc_nxt = '0;
        if (bus.req) begin
          w_state_nxt = ST_RUN;
          w_sp_nxt    = '0;
          w_err_nxt   = 1'b0;
        end
      end

      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            w_state_nxt = ST_DONE;
          end else if (bus.ret) begin
            if (!w_empty) begin
              w_pc_nxt = w_pop_data;
              w_sp_nxt = r_sp - SPW'(1);
            end else begin
              w_err_nxt = 1'b1;
              w_step    = 1'b1;
            end
          end else if (bus.call) begin
            if (!w_full) begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + SPW'(1);
              w_pc_nxt = bus.target;
            end else begin
              w_err_nxt = 1'b1;
              w_step    = 1'b1;
            end
          end else if (bus.absj) begin
            w_pc_nxt = bus.target;
          end else if (bus.relj) begin
            // D-bit add of a D-bit two's-complement offset wraps mod 2^D.
            w_pc_nxt = r_pc + bus.target;
          end else begin
            w_step = 1'b1;
          end

          // Stepping off the last address ends the program instead of wrapping.
          if (w_step) begin
            if (&r_pc) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end
      end

      ST_DONE: begin
        if (!bus.req) begin
          w_state_nxt = ST_IDLE;
          w_pc_nxt    = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_sp    <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Stack storage needs no reset: the pointer alone defines its contents.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.prog_ctr  = r_pc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.stack_err = r_err;
endmodule

// File: tb/tb_prog_seq.sv
// Self-checking bench for prog_seq: directed vector table, a hand-written
// stack-wrap sequence, then random stimulus against a behavioural model.
module tb_prog_seq;
  localparam int unsigned D = 9;
  localparam int unsigned S = 4;
  localparam int          M = 1 << D;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] H    = 5'b10000;
  localparam logic [4:0] R    = 5'b01000;
  localparam logic [4:0] C    = 5'b00100;
  localparam logic [4:0] A    = 5'b00010;
  localparam logic [4:0] J    = 5'b00001;

  typedef struct {
    logic       rst;
    logic       req;
    logic       stall;
    logic [4:0] ctl;
    int         tgt;
    int         pc;
    int         busy;
    int         done;
    int         err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  prog_seq_if #(.D(D)) bus ();

  prog_seq #(.D(D), .S(S)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];

  // Behavioural reference: 0 idle, 1 run, 2 done; stack as a queue.
  int m_state = 0;
  int m_pc    = 0;
  int m_stack[$];
  bit m_err   = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic model_step();
    bit inc;
    int off;
    int tgt;
    inc = 1'b0;
    tgt = int'(bus.target);
    if (reset) begin
      m_state = 0; m_pc = 0; m_err = 1'b0; m_stack.delete();
    end else if (m_state == 0) begin
      m_pc = 0;
      if (bus.req) begin
        m_state = 1; m_err = 1'b0; m_stack.delete();
      end
    end else if (m_state == 1) begin
      if (!bus.stall) begin
        if (bus.halt) m_state = 2;
        else if (bus.ret) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_err = 1'b1; inc = 1'b1; end
        end else if (bus.call) begin
          if (m_stack.size() < S) begin
            m_stack.push_back((m_pc + 1) % M);
            m_pc = tgt;
          end else begin m_err = 1'b1; inc = 1'b1; end
        end else if (bus.absj) m_pc = tgt;
        else if (bus.relj) begin
          off  = (tgt >= M / 2) ? tgt - M : tgt;
          m_pc = (m_pc + off + M) % M;
        end else inc = 1'b1;
        if (inc) begin
          if (m_pc == M - 1) m_state = 2;
          else m_pc = m_pc + 1;
        end
      end
    end else begin
      if (!bus.req) begin m_state = 0; m_pc = 0; end
    end
  endtask

  task automatic drive(input logic rst, input logic rq, input logic st,
                       input logic [4:0] ctl, input int tgt);
    reset     = rst;
    bus.req   = rq;
    bus.stall = st;
    {bus.halt, bus.ret, bus.call, bus.absj, bus.relj} = ctl;
    bus.target = D'(tgt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int pc, input int b, input int d, input int e);
    chk({tag, ".pc"},   int'(bus.prog_ctr),  pc);
    chk({tag, ".busy"}, int'(bus.busy),      b);
    chk({tag, ".done"}, int'(bus.done),      d);
    chk({tag, ".err"},  int'(bus.stack_err), e);
  endtask

  task automatic step(input string tag, input logic rst, input logic rq, input logic st,
                      input logic [4:0] ctl, input int tgt,
                      input int pc, input int b, input int d, input int e);
    drive(rst, rq, st, ctl, tgt);
    tick();
    chk_out(tag, pc, b, d, e);
  endtask

  function automatic void add(input logic rst, input logic rq, input logic st,
                              input logic [4:0] ctl, input int tgt,
                              input int pc, input int b, input int d, input int e);
    vec_t v;
    v.rst = rst; v.req = rq; v.stall = st; v.ctl = ctl; v.tgt = tgt;
    v.pc = pc; v.busy = b; v.done = d; v.err = e;
    tbl.push_back(v);
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, NONE, 0);

    // Start and step.
    add(1, 0, 0, NONE, 0,     0, 0, 0, 0);
    add(0, 1, 0, NONE, 0,     0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, NONE, 0, k, 1, 0, 0);
    // Call / return.
    add(1, 0, 0, NONE, 0,     0, 0, 0, 0);
    add(0, 1, 0, NONE, 0,     0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, NONE, 0, k, 1, 0, 0);
    add(0, 0, 0, C, 'h40,     'h40, 1, 0, 0);
    add(0, 0, 0, R, 0,        4, 1, 0, 0);
    add(0, 0, 0, NONE, 0,     5, 1, 0, 0);
    // Overflow on the fifth nested call, LIFO unwinding, then underflow.
    add(0, 0, 0, C, 'h10,     'h10, 1, 0, 0);
    add(0, 0, 0, C, 'h20,     'h20, 1, 0, 0);
    add(0, 0, 0, C, 'h30,     'h30, 1, 0, 0);
    add(0, 0, 0, C, 'h50,     'h50, 1, 0, 0);
    add(0, 0, 0, C, 'h60,     'h51, 1, 0, 1);
    add(0, 0, 0, R, 0,        'h31, 1, 0, 1);
    add(0, 0, 0, R, 0,        'h21, 1, 0, 1);
    add(0, 0, 0, R, 0,        'h11, 1, 0, 1);
    add(0, 0, 0, R, 0,        6, 1, 0, 1);
    add(0, 0, 0, R, 0,        7, 1, 0, 1);
    // Priority of absj over relj, then relj by -10.
    for (int k = 8; k <= 10; k++) add(0, 0, 0, NONE, 0, k, 1, 0, 1);
    add(0, 0, 0, A | J, 'h1F6, 'h1F6, 1, 0, 1);
    add(0, 0, 0, A, 10,       10, 1, 0, 1);
    add(0, 0, 0, J, 'h1F6,    0, 1, 0, 1);
    // End of address space and done handshake; controls ignored outside RUN.
    add(0, 0, 0, A, 'h1FF,    'h1FF, 1, 0, 1);
    add(0, 0, 0, NONE, 0,     'h1FF, 0, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 0, C, 'h20, 'h1FF, 0, 1, 1);
    add(0, 0, 0, NONE, 0,     0, 0, 0, 1);
    add(0, 0, 0, C | A, 'h30, 0, 0, 0, 1);
    add(0, 1, 0, NONE, 0,     0, 1, 0, 0);
    add(0, 0, 0, NONE, 0,     1, 1, 0, 0);
    // Stall holds everything: no push happens, so the ret underflows.
    for (int k = 0; k < 3; k++) add(0, 0, 1, C, 'h80, 1, 1, 0, 0);
    add(0, 0, 0, R, 0,        2, 1, 0, 1);
    for (int k = 3; k <= 7; k++) add(0, 0, 0, NONE, 0, k, 1, 0, 1);
    // Reset mid-run aborts; a fresh req is needed.
    add(1, 0, 0, C, 'h80,     0, 0, 0, 0);
    add(0, 0, 0, NONE, 0,     0, 0, 0, 0);
    add(0, 1, 0, NONE, 0,     0, 1, 0, 0);
    add(0, 0, 0, H | R | C, 'h55, 0, 0, 1, 0);
    add(0, 0, 0, NONE, 0,     0, 0, 0, 0);
    // Underflow fallback at the last address ends the program.
    add(0, 1, 0, NONE, 0,     0, 1, 0, 0);
    add(0, 0, 0, A, 'h1FF,    'h1FF, 1, 0, 0);
    add(0, 0, 0, R, 0,        'h1FF, 0, 1, 1);
    add(0, 0, 0, NONE, 0,     0, 0, 0, 1);

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].stall, tbl[i].ctl,
           tbl[i].tgt, tbl[i].pc, tbl[i].busy, tbl[i].done, tbl[i].err);
    end

    // Call from the last address pushes a wrapped 0; full-stack call at the top ends.
    step("wrap0", 0, 1, 0, NONE, 0,     0, 1, 0, 0);
    step("wrap1", 0, 0, 0, C, 'h1FF,    'h1FF, 1, 0, 0);
    step("wrap2", 0, 0, 0, C, 'h1FF,    'h1FF, 1, 0, 0);
    step("wrap3", 0, 0, 0, R, 0,        0, 1, 0, 0);
    step("wrap4", 0, 0, 0, C, 'h1FF,    'h1FF, 1, 0, 0);
    step("wrap5", 0, 0, 0, C, 'h1FF,    'h1FF, 1, 0, 0);
    step("wrap6", 0, 0, 0, C, 'h1FF,    'h1FF, 1, 0, 0);
    step("wrap7", 0, 0, 0, C, 'h1FF,    'h1FF, 0, 1, 1);
    step("wrap8", 0, 0, 0, NONE, 0,     0, 0, 0, 1);

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ctl;
      int         tgt;
      ctl[4] = ($urandom_range(0, 39) == 0);
      ctl[3] = ($urandom_range(0, 4) == 0);
      ctl[2] = ($urandom_range(0, 3) == 0);
      ctl[1] = ($urandom_range(0, 7) == 0);
      ctl[0] = ($urandom_range(0, 5) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(M - 16, M - 1))
                                        : int'($urandom_range(0, M - 1));
      drive(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ctl, tgt);
      tick();
      chk_out($sformatf("rnd%0d", i), m_pc, int'(m_state == 1), int'(m_state == 2), int'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 The module SHALL have parameter D, default 9, meaning program counter width in bits.
REQ-002 The module SHALL have parameter S, default 4, meaning return-stack depth in entries (S >= 1).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 The module SHALL have port req  input  1  meaning program start request / done acknowledge.
REQ-006 The module SHALL have port stall  input  1  meaning hold all state this cycle.
REQ-007 The module SHALL have port halt  input  1  meaning current instruction ends the program.
REQ-008 The module SHALL have port ret  input  1  meaning return to the popped stack address.
REQ-009 The module SHALL have port call  input  1  meaning push the return address and jump to target.
REQ-010 The module SHALL have port absj  input  1  meaning absolute jump to target.
REQ-011 The module SHALL have port relj  input  1  meaning relative jump by signed target.
REQ-012 The module SHALL have port target  input  D  meaning jump address, or two's-complement offset for relj.
REQ-013 The module SHALL have port prog_ctr  output  D  meaning current instruction address.
REQ-014 The module SHALL have port busy  output  1  meaning program running.
REQ-015 The module SHALL have port done  output  1  meaning program finished.
REQ-016 The module SHALL have port stack_err  output  1  meaning sticky flag for return-stack overflow or underflow.

Function
REQ-017 The module SHALL implement the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-018 In IDLE: prog_ctr = 0, busy = 0, done = 0; when req = 1 the module SHALL go to RUN on the next edge, clear stack_err and the stack pointer, and hold prog_ctr at 0.
REQ-019 In RUN: busy = 1; in every cycle with stall = 0, exactly one action SHALL apply, highest priority first: halt > ret > call > absj > relj > increment.
REQ-020 halt SHALL go to DONE and hold prog_ctr.
REQ-021 ret with a non-empty stack SHALL pop, setting prog_ctr to the popped value.
REQ-022 ret with an empty stack SHALL set prog_ctr to prog_ctr+1 and set stack_err.
REQ-023 call with stack not full SHALL push (prog_ctr+1) mod 2^D and set prog_ctr to target.
REQ-024 call with the stack full (S entries) SHALL perform no push, set prog_ctr to prog_ctr+1 and set stack_err.
REQ-025 absj SHALL set prog_ctr to target.
REQ-026 relj SHALL set prog_ctr to (prog_ctr + sign-extended target) mod 2^D, wrapping silently.
REQ-027 increment SHALL set prog_ctr to prog_ctr+1.
REQ-028 An increment (plain, or the fallback of REQ-022/REQ-024) at prog_ctr = 2^D-1 SHALL go to DONE with prog_ctr held at 2^D-1 and no wrap.
REQ-029 When stall = 1 in RUN, all state SHALL hold and all control inputs SHALL be ignored.
REQ-030 In RUN, req SHALL be ignored; the program SHALL run until halt or end of address space.
REQ-031 In DONE: done = 1, busy = 0, prog_ctr held; the module SHALL stay in DONE while req = 1, and on req = 0 go to IDLE on the next edge with prog_ctr = 0 and done = 0.
REQ-032 stack_err SHALL remain set through DONE and IDLE until the next IDLE->RUN transition.
REQ-033 Control inputs SHALL be ignored in IDLE and DONE.

Reset
REQ-034 With reset = 1 at a rising edge, the module SHALL go to IDLE with prog_ctr = 0, busy = 0, done = 0, stack_err = 0 and an empty stack, regardless of state, req or stall.
REQ-035 Reset asserted mid-RUN SHALL abort the program; after reset deasserts, a new req SHALL be required to start.

Verification
REQ-036 Start and step: reset, req = 1, no controls, 5 cycles -> prog_ctr sequence 0,1,2,3,4; busy = 1 from the first RUN cycle.
REQ-037 Call/return: at prog_ctr = 3, call with target = 0x40; at 0x40, ret -> prog_ctr 0x40 then 4; stack_err = 0.
REQ-038 Overflow: with S = 4, five nested calls -> the fifth call gives prog_ctr+1 and stack_err = 1; four rets then return in LIFO order.
REQ-039 Priority and relj: at prog_ctr = 10, assert absj (target = 0x1F6) with relj in the same cycle -> prog_ctr = 0x1F6; then relj with target = 0x1F6 (-10) at prog_ctr = 10 -> 0.
REQ-040 End and handshake: absj to 0x1FF, then no controls -> DONE with done = 1 and prog_ctr = 0x1FF; hold req = 1 for 3 cycles -> done stays 1; drop req -> IDLE with prog_ctr = 0 on the next edge.
REQ-041 Stall and reset: stall = 1 for 3 cycles with call asserted -> prog_ctr and stack unchanged; reset mid-RUN at prog_ctr = 7 -> prog_ctr = 0, busy = 0 next cycle.
